// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: control FSM for a multicycle RV32 datapath.
// Sequences fetch/decode/execute/memory/writeback, counts retired
// instructions, bounds memory waits with MEM_TIMEOUT and latches faults.
// Optional feature: define MULDIV_EN to send M-extension ops to a MULDIV state.
module multicycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic             zero,
  input  logic             alu_lsb,
  input  logic             mem_ready,
  input  logic             md_done,
  output logic             mem_req,
  output logic             mem_write,
  output logic             adr_src,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic             reg_write,
  output logic [2:0]       result_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [2:0]       imm_src,
  output logic             md_start,
  output logic             fault,
  output logic             illegal_instr,
  output logic             timeout,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instret
);

  localparam int unsigned WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LIMIT =
    (MEM_TIMEOUT > 0) ? WAIT_W'(MEM_TIMEOUT - 1) : '0;
  localparam logic TIMEOUT_EN = (MEM_TIMEOUT > 0);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_MULDIV   = 4'd11,
    S_FAULT    = 4'd15
  } state_t;

  state_t            cur, nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              fault_q, illegal_q, timeout_q;
  logic [CNT_W-1:0]  instret_q;
  logic              set_illegal, set_timeout, retire;
  logic              limit_hit, taken, is_muldiv;

`ifdef MULDIV_EN
  logic md_started;
  assign is_muldiv = (funct7 == 7'b0000001);
`else
  logic unused_inputs;
  assign is_muldiv     = 1'b0;
  assign unused_inputs = ^{md_done, funct7};
`endif

  assign limit_hit = TIMEOUT_EN && (wait_cnt == WAIT_LIMIT);

  // Branch condition from the ALU flags selected by funct3
  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'b000:         taken = zero;
      3'b001:         taken = ~zero;
      3'b100, 3'b110: taken = alu_lsb;
      3'b101, 3'b111: taken = ~alu_lsb;
      default:        taken = 1'b0;
    endcase
  end

  // Next-state and control decode from the current state and inputs
  always_comb begin
    nxt         = cur;
    mem_req     = 1'b0;
    mem_write   = 1'b0;
    adr_src     = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    pc_src      = 1'b0;
    reg_write   = 1'b0;
    result_src  = 3'b000;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    alu_op      = 2'b00;
    imm_src     = 3'b000;
    md_start    = 1'b0;
    set_illegal = 1'b0;
    set_timeout = 1'b0;
    retire      = 1'b0;
    case (cur)
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 3'b010;
        if (mem_ready) begin
          // an acknowledge seen while reset is held must not update IR/PC
          ir_write = ~reset;
          pc_write = ~reset;
          nxt      = S_DECODE;
        end else if (limit_hit) begin
          nxt         = S_FAULT;
          set_timeout = 1'b1;
        end
      end
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE:                  nxt = S_MEMADR;
          OP_RTYPE:                           nxt = is_muldiv ? S_MULDIV : S_EXECUTER;
          OP_IMM, OP_JALR, OP_LUI, OP_AUIPC:  nxt = S_EXECUTEI;
          OP_JAL:                             nxt = S_JAL;
          OP_BRANCH:                          nxt = S_BRANCH;
          default: begin
            nxt         = S_FAULT;
            set_illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        nxt       = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (mem_ready) begin
          nxt = S_MEMWB;
        end else if (limit_hit) begin
          nxt         = S_FAULT;
          set_timeout = 1'b1;
        end
      end
      S_MEMWRITE: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_src   = 1'b1;
        if (mem_ready) begin
          nxt    = S_FETCH;
          retire = 1'b1;
        end else if (limit_hit) begin
          nxt         = S_FAULT;
          set_timeout = 1'b1;
        end
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        result_src = 3'b001;
        nxt        = S_FETCH;
        retire     = 1'b1;
      end
      S_EXECUTER: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
        nxt       = S_ALUWB;
      end
      S_EXECUTEI: begin
        alu_src_b = 2'b01;
        if (funct3 == 3'b001 || funct3 == 3'b101) imm_src = 3'b101;
        nxt = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        if (op == OP_RTYPE && is_muldiv)           result_src = 3'b101;
        else if (op == OP_LUI)                     result_src = 3'b011;
        else if (op == OP_JAL || op == OP_JALR)    result_src = 3'b100;
        else                                       result_src = 3'b000;
        nxt    = S_FETCH;
        retire = 1'b1;
      end
      S_BRANCH: begin
        alu_op   = 2'b11;
        pc_write = taken;
        pc_src   = taken;
        nxt      = S_FETCH;
        retire   = 1'b1;
      end
      S_JAL: begin
        pc_write = 1'b1;
        pc_src   = 1'b1;
        imm_src  = 3'b100;
        nxt      = S_ALUWB;
      end
`ifdef MULDIV_EN
      S_MULDIV: begin
        md_start = ~md_started;
        if (md_done) nxt = S_ALUWB;
      end
`endif
      S_FAULT: nxt = S_FAULT;
      default: nxt = S_FAULT;
    endcase
  end

  // State, wait counter, sticky flags and retired-instruction counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur        <= S_FETCH;
      wait_cnt   <= '0;
      fault_q    <= 1'b0;
      illegal_q  <= 1'b0;
      timeout_q  <= 1'b0;
      instret_q  <= '0;
`ifdef MULDIV_EN
      md_started <= 1'b0;
`endif
    end else begin
      cur <= nxt;
      if (nxt != cur)                 wait_cnt <= '0;
      else if (mem_req && !mem_ready) wait_cnt <= wait_cnt + WAIT_W'(1);
      if (nxt == S_FAULT) fault_q   <= 1'b1;
      if (set_illegal)    illegal_q <= 1'b1;
      if (set_timeout)    timeout_q <= 1'b1;
      if (retire)         instret_q <= instret_q + CNT_W'(1);
`ifdef MULDIV_EN
      md_started <= (cur == S_MULDIV) && (nxt == S_MULDIV);
`endif
    end
  end

  assign state         = cur;
  assign fault         = fault_q;
  assign illegal_instr = illegal_q;
  assign timeout       = timeout_q;
  assign instret       = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed and randomized checks of multicycle_ctrl
// against an instruction-path reference model.
`timescale 1ns/1ps
module tb_multicycle_ctrl;

  localparam int unsigned M_TO = 16;
  localparam int unsigned M_CW = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, zero, alu_lsb, mem_ready, md_done;
  logic [6:0] op, funct7;
  logic [2:0] funct3;

  logic            mem_req, mem_write, adr_src, ir_write, pc_write, pc_src, reg_write;
  logic [2:0]      result_src, imm_src;
  logic [1:0]      alu_src_a, alu_src_b, alu_op;
  logic            md_start, fault, illegal_instr, timeout;
  logic [3:0]      state;
  logic [M_CW-1:0] instret;

  logic        t_reset, t_mem_ready;
  logic        t_mem_req, t_mem_write, t_adr_src, t_ir_write, t_pc_write, t_pc_src, t_reg_write;
  logic [2:0]  t_result_src, t_imm_src;
  logic [1:0]  t_alu_src_a, t_alu_src_b, t_alu_op;
  logic        t_md_start, t_fault, t_illegal_instr, t_timeout;
  logic [3:0]  t_state;
  logic [31:0] t_instret;

  multicycle_ctrl #(.MEM_TIMEOUT(M_TO), .CNT_W(M_CW)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7(funct7),
    .zero(zero), .alu_lsb(alu_lsb), .mem_ready(mem_ready), .md_done(md_done),
    .mem_req(mem_req), .mem_write(mem_write), .adr_src(adr_src), .ir_write(ir_write),
    .pc_write(pc_write), .pc_src(pc_src), .reg_write(reg_write), .result_src(result_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .imm_src(imm_src),
    .md_start(md_start), .fault(fault), .illegal_instr(illegal_instr), .timeout(timeout),
    .state(state), .instret(instret)
  );

  multicycle_ctrl #(.MEM_TIMEOUT(4)) dut4 (
    .clk(clk), .reset(t_reset), .op(op), .funct3(funct3), .funct7(funct7),
    .zero(zero), .alu_lsb(alu_lsb), .mem_ready(t_mem_ready), .md_done(md_done),
    .mem_req(t_mem_req), .mem_write(t_mem_write), .adr_src(t_adr_src), .ir_write(t_ir_write),
    .pc_write(t_pc_write), .pc_src(t_pc_src), .reg_write(t_reg_write), .result_src(t_result_src),
    .alu_src_a(t_alu_src_a), .alu_src_b(t_alu_src_b), .alu_op(t_alu_op), .imm_src(t_imm_src),
    .md_start(t_md_start), .fault(t_fault), .illegal_instr(t_illegal_instr), .timeout(t_timeout),
    .state(t_state), .instret(t_instret)
  );

  // ---------------- reference model: instruction as a path of phases
  int          m_st, m_age;
  bit          m_ill, m_to, m_md;
  int unsigned m_inst;
  int          path[$];

  function automatic void set_path(input int a, input int b, input int c);
    path.delete();
    if (a >= 0) path.push_back(a);
    if (b >= 0) path.push_back(b);
    if (c >= 0) path.push_back(c);
  endfunction

  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_st = 0; m_age = 0; m_ill = 0; m_to = 0; m_md = 0; m_inst = 0;
        path.delete();
      end else begin
        int nx;
        bit adv;
        nx  = m_st;
        adv = 0;
        case (m_st)
          0, 3, 5: begin
            if (mem_ready) adv = 1;
            else if (M_TO > 0 && m_age == int'(M_TO) - 1) begin nx = 15; m_to = 1; end
          end
          1: begin
            m_md = 0;
            case (op)
              7'h03:                      set_path(2, 3, 4);
              7'h23:                      set_path(2, 5, -1);
              7'h33: begin
                set_path(6, 8, -1);
`ifdef MULDIV_EN
                if (funct7 == 7'b0000001) begin set_path(11, 8, -1); m_md = 1; end
`endif
              end
              7'h13, 7'h67, 7'h37, 7'h17: set_path(7, 8, -1);
              7'h6F:                      set_path(10, 8, -1);
              7'h63:                      set_path(9, -1, -1);
              default:                    set_path(15, -1, -1);
            endcase
            nx = path.pop_front();
            if (nx == 15) m_ill = 1;
          end
          11: adv = md_done;
          15: adv = 0;
          default: adv = 1;
        endcase
        if (adv) begin
          if (m_st == 0)             nx = 1;
          else if (path.size() > 0)  nx = path.pop_front();
          else                       nx = 0;
        end
        if (nx == 0 && m_st != 0) m_inst = (m_inst + 1) % (32'd1 << M_CW);
        m_age = (nx == m_st) ? m_age + 1 : 0;
        m_st  = nx;
      end
    end
  end

  // ---------------- checking
  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_cycle();
    logic [26:0] a, e;
    logic mr, mw, as, irw, pcw, pcs, rw, ms, tk;
    logic [2:0] rs, is;
    logic [1:0] sa, sb, ao;
    {mr, mw, as, irw, pcw, pcs, rw, ms} = '0;
    rs = '0; is = '0; sa = '0; sb = '0; ao = '0;
    tk = 1'b0;
    if (funct3 != 3'd2 && funct3 != 3'd3) tk = (funct3[2] ? alu_lsb : zero) ^ funct3[0];
    case (m_st)
      0:  begin mr = 1; sb = 2; rs = 2; irw = mem_ready & ~reset; pcw = mem_ready & ~reset; end
      2:  begin sa = 2; sb = 1; end
      3:  begin mr = 1; as = 1; end
      4:  begin rw = 1; rs = 1; end
      5:  begin mr = 1; mw = 1; as = 1; end
      6:  begin sa = 2; ao = 2; end
      7:  begin sb = 1; is = (funct3 == 3'd1 || funct3 == 3'd5) ? 3'd5 : 3'd0; end
      8:  begin
        rw = 1;
        rs = m_md ? 3'd5 : (op == 7'h37) ? 3'd3 : (op == 7'h6F || op == 7'h67) ? 3'd4 : 3'd0;
      end
      9:  begin ao = 3; pcw = tk; pcs = tk; end
      10: begin pcw = 1; pcs = 1; is = 4; end
      11: ms = (m_age == 0);
      default: ;
    endcase
    a = {mem_req, mem_write, adr_src, ir_write, pc_write, pc_src, reg_write, result_src,
         alu_src_a, alu_src_b, alu_op, imm_src, md_start, fault, illegal_instr, timeout, state};
    e = {mr, mw, as, irw, pcw, pcs, rw, rs, sa, sb, ao, is, ms,
         1'(m_st == 15), 1'(m_ill), 1'(m_to), 4'(m_st)};
    chk("ctl", 64'(a), 64'(e));
    chk("instret", 64'(instret), 64'(m_inst));
  endtask

  // snapshots taken at the sampling edge of the last cycle
  logic [3:0] s_state, t_s_state;
  logic       s_pcw, s_rw, s_ill, s_fault, s_mr, s_ms, s_strb;
  logic       t_s_to, t_s_fault, t_s_strb;
  logic [2:0] s_rs;
  logic [M_CW-1:0] s_inst;

  task automatic tick();
    @(negedge clk);
    cmp_cycle();
    s_state = state; s_pcw = pc_write; s_rw = reg_write; s_ill = illegal_instr;
    s_fault = fault; s_mr = mem_req; s_ms = md_start; s_rs = result_src; s_inst = instret;
    s_strb  = |{mem_req, mem_write, ir_write, pc_write, reg_write, md_start};
    t_s_state = t_state; t_s_to = t_timeout; t_s_fault = t_fault;
    t_s_strb  = |{t_mem_req, t_mem_write, t_ir_write, t_pc_write, t_reg_write, t_md_start};
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  logic [6:0] legal_ops [9] = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h67, 7'h37, 7'h17, 7'h6F, 7'h63};
  logic [6:0] bad_ops   [5] = '{7'h7F, 7'h00, 7'h0F, 7'h73, 7'h2F};

  task automatic pick_instr();
    if ($urandom_range(0, 19) == 0) op = bad_ops[$urandom_range(0, 4)];
    else                            op = legal_ops[$urandom_range(0, 8)];
    funct3 = 3'($urandom);
    funct7 = ($urandom_range(0, 1) == 1) ? 7'b0000001 : 7'($urandom);
  endtask

  initial begin
    int seq[10];
    int cnt;
    reset = 1'b1; t_reset = 1'b1; t_mem_ready = 1'b0;
    op = 7'h33; funct3 = 3'd0; funct7 = 7'd0;
    zero = 1'b0; alu_lsb = 1'b0; mem_ready = 1'b0; md_done = 1'b0;
    @(posedge clk); #1;

    // reset state
    apply_reset();
    chk("rst_state", 64'(s_state), 64'(0));
    chk("rst_mem_req", 64'(s_mr), 64'(1));
    chk("rst_instret", 64'(s_inst), 64'(0));
    chk("rst_fault", 64'(s_fault), 64'(0));

    // add x1,x2,x3 with memory always ready
    op = 7'h33; funct3 = 3'd0; funct7 = 7'd0; mem_ready = 1'b1;
    apply_reset();
    cnt = 0;
    for (int i = 0; i < 5; i++) begin tick(); seq[i] = int'(s_state); cnt += int'(s_rw); end
    chk("add_states", 64'({4'(seq[0]), 4'(seq[1]), 4'(seq[2]), 4'(seq[3]), 4'(seq[4])}), 64'(20'h01680));
    chk("add_regwrite_cycles", 64'(cnt), 64'(1));
    chk("add_instret", 64'(s_inst), 64'(1));

    // lw with three stall cycles in MEMREAD
    op = 7'h03; funct3 = 3'd2;
    apply_reset();
    cnt = 0;
    for (int c = 0; c < 9; c++) begin
      mem_ready = !(c >= 3 && c <= 5);
      tick();
      seq[c % 10] = int'(s_state);
      cnt += int'(s_fault);
    end
    chk("lw_states_a", 64'({4'(seq[0]), 4'(seq[1]), 4'(seq[2]), 4'(seq[3]), 4'(seq[4])}), 64'(20'h01233));
    chk("lw_states_b", 64'({4'(seq[5]), 4'(seq[6]), 4'(seq[7]), 4'(seq[8])}), 64'(16'h3340));
    chk("lw_no_fault", 64'(cnt), 64'(0));

    // beq then bne, both with zero=1
    op = 7'h63; funct3 = 3'd0; zero = 1'b1; mem_ready = 1'b1;
    apply_reset();
    for (int c = 0; c < 7; c++) begin
      if (c == 3) funct3 = 3'd1;
      tick();
      seq[c] = int'(s_state);
      if (c == 2) chk("beq_pc_write", 64'(s_pcw), 64'(1));
      if (c == 5) chk("bne_pc_write", 64'(s_pcw), 64'(0));
    end
    chk("br_states", 64'({4'(seq[2]), 4'(seq[5]), 4'(seq[6])}), 64'(12'h990));
    chk("br_instret", 64'(s_inst), 64'(2));

    // illegal opcode
    op = 7'h7F;
    apply_reset();
    for (int c = 0; c < 4; c++) begin tick(); seq[c] = int'(s_state); end
    chk("ill_states", 64'({4'(seq[0]), 4'(seq[1]), 4'(seq[2]), 4'(seq[3])}), 64'(16'h01FF));
    chk("ill_flag", 64'(s_ill), 64'(1));
    chk("ill_fault", 64'(s_fault), 64'(1));
    chk("ill_strobes", 64'(s_strb), 64'(0));
    apply_reset();
    chk("ill_reset_state", 64'(s_state), 64'(0));
    chk("ill_reset_flag", 64'(s_ill), 64'(0));

    // mul (funct7=0000001) with md_done arriving late
    op = 7'h33; funct3 = 3'd0; funct7 = 7'b0000001; md_done = 1'b0;
    apply_reset();
    cnt = 0;
    for (int c = 0; c < 10; c++) begin
      md_done = (c == 7);
      tick();
      seq[c] = int'(s_state);
      cnt += int'(s_ms);
`ifdef MULDIV_EN
      if (c == 8) chk("mul_result_src", 64'(s_rs), 64'(5));
`endif
    end
    md_done = 1'b0;
`ifdef MULDIV_EN
    chk("mul_states", 64'({4'(seq[2]), 4'(seq[7]), 4'(seq[8]), 4'(seq[9])}), 64'(16'hBB80));
    chk("mul_md_start_pulses", 64'(cnt), 64'(1));
`else
    chk("mul_states", 64'({4'(seq[2]), 4'(seq[3]), 4'(seq[4])}), 64'(12'h680));
    chk("mul_md_start_pulses", 64'(cnt), 64'(0));
`endif

    // instret wrap: 65 back-to-back adds on a 6-bit counter
    funct7 = 7'd0; mem_ready = 1'b1;
    apply_reset();
    repeat (257) tick();
    chk("wrap_at_64", 64'(s_inst), 64'(0));
    repeat (4) tick();
    chk("wrap_plus_one", 64'(s_inst), 64'(1));

    // MEM_TIMEOUT=4: fetch never acknowledged
    t_mem_ready = 1'b0;
    t_reset = 1'b1; tick(); tick(); t_reset = 1'b0;
    for (int c = 0; c < 5; c++) begin tick(); seq[c] = int'(t_s_state); end
    chk("to_states", 64'({4'(seq[0]), 4'(seq[1]), 4'(seq[2]), 4'(seq[3]), 4'(seq[4])}), 64'(20'h0000F));
    chk("to_flag", 64'(t_s_to), 64'(1));
    chk("to_fault", 64'(t_s_fault), 64'(1));
    chk("to_strobes", 64'(t_s_strb), 64'(0));

    // MEM_TIMEOUT=4: acknowledge on the limit cycle completes normally
    t_reset = 1'b1; tick(); tick(); t_reset = 1'b0;
    for (int c = 0; c < 5; c++) begin t_mem_ready = (c == 3); tick(); seq[c] = int'(t_s_state); end
    chk("limit_ack_states", 64'({4'(seq[3]), 4'(seq[4])}), 64'(8'h01));
    chk("limit_ack_no_timeout", 64'(t_s_to), 64'(0));

    // randomized instruction streams, some segments with a starved memory
    for (int seg = 0; seg < 8; seg++) begin
      int rdy_pct;
      rdy_pct = (seg % 4 == 3) ? 8 : 40 + 15 * (seg % 4);
      apply_reset();
      for (int k = 0; k < 400; k++) begin
        if (m_st == 0) pick_instr();
        mem_ready = ($urandom_range(0, 99) < rdy_pct);
        md_done   = ($urandom_range(0, 3) == 0);
        zero      = 1'($urandom);
        alu_lsb   = 1'($urandom);
        reset     = ($urandom_range(0, 249) == 0) || (m_st == 15 && $urandom_range(0, 19) == 0);
        tick();
      end
      reset = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
